// File: rtl/cpu_step_controller.sv
// Turns the divided slow clock or a debounced step button into a single-cycle
// cpu_en pulse in the clk_in domain; cpu_halt freezes issue until released.
module cpu_step_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             slow_clk,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic             cpu_halt,
    output logic             cpu_en,
    output logic             run_mode,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_slow_s1, r_slow_s2, r_slow_prev;
    logic            r_btn_s1, r_btn_s2, r_btn_db, r_btn_db_prev;
    logic            r_run_s1, r_run_s2, r_run_db;
    logic [DB_W-1:0] r_btn_cnt, r_run_cnt;
    logic [1:0]      r_state;

    logic       w_tick;
    logic       w_step_req;
    logic       w_pulse;
    logic [1:0] w_next;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_slow_s1     <= 1'b0;
            r_slow_s2     <= 1'b0;
            r_slow_prev   <= 1'b0;
            r_btn_s1      <= 1'b0;
            r_btn_s2      <= 1'b0;
            r_btn_db_prev <= 1'b0;
            r_run_s1      <= 1'b0;
            r_run_s2      <= 1'b0;
        end else begin
            r_slow_s1     <= slow_clk;
            r_slow_s2     <= r_slow_s1;
            r_slow_prev   <= r_slow_s2;
            r_btn_s1      <= btn_step;
            r_btn_s2      <= r_btn_s1;
            r_btn_db_prev <= r_btn_db;
            r_run_s1      <= sw_run;
            r_run_s2      <= r_run_s1;
        end
    end

    // The debounced value only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_btn_db  <= 1'b0;
            r_btn_cnt <= '0;
        end else if (r_btn_s2 == r_btn_db) begin
            r_btn_cnt <= '0;
        end else if (r_btn_cnt == DB_LAST) begin
            r_btn_db  <= r_btn_s2;
            r_btn_cnt <= '0;
        end else begin
            r_btn_cnt <= r_btn_cnt + DB_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_run_db  <= 1'b0;
            r_run_cnt <= '0;
        end else if (r_run_s2 == r_run_db) begin
            r_run_cnt <= '0;
        end else if (r_run_cnt == DB_LAST) begin
            r_run_db  <= r_run_s2;
            r_run_cnt <= '0;
        end else begin
            r_run_cnt <= r_run_cnt + DB_W'(1);
        end
    end

    assign w_tick     = r_slow_s2 & ~r_slow_prev;
    assign w_step_req = r_btn_db & ~r_btn_db_prev;

    always_comb begin
        w_next  = r_state;
        w_pulse = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_halt)        w_next = S_HALT;
                else if (r_run_db)   w_next = S_RUN;
                else if (w_step_req) w_pulse = 1'b1;
            end
            S_RUN: begin
                if (cpu_halt) begin
                    w_next = S_HALT;
                end else begin
                    w_pulse = w_tick;
                    if (!r_run_db) w_next = S_IDLE;
                end
            end
            S_HALT: begin
                if (!r_run_db && !cpu_halt) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            cpu_en     <= 1'b0;
            run_mode   <= 1'b0;
            halted     <= 1'b0;
            step_count <= '0;
        end else begin
            r_state  <= w_next;
            cpu_en   <= w_pulse;
            run_mode <= (w_next == S_RUN);
            halted   <= (w_next == S_HALT);
            if (w_pulse) step_count <= step_count + CNT_W'(1);
        end
    end

endmodule
